led_rate_sequencer: RTL and testbench

Controller that schedules the LED blink-rate selector and enable for the LED blink block. It steps through a four-entry pattern of blink rates, holding each for a fixed dwell time. A debounced push-button starts, pauses and resumes the sequence. It sits between the board button/pattern switches and the blink block's `{sw1,sw2}` select and enable inputs.

---
 rtl/led_rate_sequencer.sv | 93 +++++++++
 tb/tb_led_rate_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/led_rate_sequencer.sv
// led_rate_sequencer: steps the blink-rate select through a 4-entry pattern, button starts/pauses/resumes.
// Define LED_SEQ_ONESHOT_EN to return to IDLE after one pass instead of wrapping.
module led_rate_sequencer #(
  parameter int DWELL_TICKS    = 125000000,
  parameter int DEBOUNCE_TICKS = 1250000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  input  logic [7:0] i_pattern,
  output logic [1:0] o_sel,
  output logic       o_enable,
  output logic [1:0] o_step,
  output logic       o_running,
  output logic       o_wrap
);
  localparam int DWW = $clog2(DWELL_TICKS);
  localparam int DBW = $clog2(DEBOUNCE_TICKS);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic s1, s2, lvl, lvl_q, press, db_hit, expire;
  logic [DBW-1:0] db_cnt;
  logic [DWW-1:0] dwell;
  logic [7:0] pat;
  logic [1:0] nstep;
  assign db_hit = db_cnt == DBW'(DEBOUNCE_TICKS - 1);
  assign expire = dwell == DWW'(DWELL_TICKS - 1);
  assign nstep  = o_step + 2'd1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      {s1, s2, lvl, lvl_q, press} <= '0;
      db_cnt <= '0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
      db_cnt <= (s2 == lvl || db_hit) ? '0 : db_cnt + 1'b1;
      if (s2 != lvl && db_hit) lvl <= s2;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      pat <= '0;
      dwell <= '0;
      o_sel <= '0;
      o_enable <= 1'b0;
      o_step <= '0;
      o_running <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= 1'b0;
      case (state)
        IDLE: if (press) begin
          state <= RUN;
          pat <= i_pattern;
          dwell <= '0;
          o_step <= '0;
          o_sel <= i_pattern[1:0];
          o_enable <= 1'b1;
          o_running <= 1'b1;
        end
        RUN: begin
          dwell <= expire ? '0 : dwell + 1'b1;
          // a press coinciding with expiry still advances; the pause then holds the new step
          if (expire) begin
            o_step <= nstep;
            o_sel <= pat[{nstep, 1'b0} +: 2];
            o_wrap <= &o_step;
          end
          if (press) begin
            state <= PAUSE;
            o_enable <= 1'b0;
            o_running <= 1'b0;
          end
`ifdef LED_SEQ_ONESHOT_EN
          if (expire && &o_step) begin
            state <= IDLE;
            o_sel <= '0;
            o_enable <= 1'b0;
            o_running <= 1'b0;
          end
`endif
        end
        PAUSE: if (press) begin
          state <= RUN;
          o_enable <= 1'b1;
          o_running <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_led_rate_sequencer.sv
// tb_led_rate_sequencer: random button/pattern stimulus against a run-time based reference model.
module tb_led_rate_sequencer;
  localparam int DW = 8;
  localparam int DB = 4;
  logic i_clk = 1'b0, i_rst = 1'b0, i_btn = 1'b0;
  logic [7:0] i_pattern = '0;
  logic [1:0] o_sel, o_step;
  logic o_enable, o_running, o_wrap;
  int total = 0, bad = 0, wraps = 0;
  logic [6:0] exp_q[$];
  led_rate_sequencer #(.DWELL_TICKS(DW), .DEBOUNCE_TICKS(DB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn), .i_pattern(i_pattern),
    .o_sel(o_sel), .o_enable(o_enable), .o_step(o_step), .o_running(o_running), .o_wrap(o_wrap)
  );
  always #5 i_clk = ~i_clk;
  // Model: debounce as "last DB synchronized samples all disagree", FSM as total RUN cycles t.
  logic bq[$];
  logic lvl, r0, r1;
  logic [7:0] pat;
  int st, t;
  always @(posedge i_clk) begin : model
    logic flip, act, rise, wr;
    int stp;
    if (i_rst) begin
      bq.delete();
      repeat (DB + 2) bq.push_front(1'b0);
      lvl = 0; r0 = 0; r1 = 0; st = 0; t = 0; pat = '0;
    end else begin
      bq.push_front(i_btn);
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (bq[2+j] == lvl) flip = 1'b0;
      void'(bq.pop_back());
      rise = flip & ~lvl;
      if (flip) lvl = ~lvl;
      act = r1; r1 = r0; r0 = rise;
      wr = 1'b0;
      if (st == 0) begin
        if (act) begin pat = i_pattern; t = 0; st = 1; end
      end else if (st == 1) begin
        t++;
        if (t % (4 * DW) == 0) begin
          wr = 1'b1;
`ifdef LED_SEQ_ONESHOT_EN
          st = 0;
          t = 0;
`endif
        end
        if (act && st == 1) st = 2;
      end else if (act) st = 1;
      stp = (st == 0) ? 0 : (t / DW) % 4;
      exp_q.push_back({(st == 0) ? 2'b00 : pat[2*stp +: 2], st == 1, 2'(stp), st == 1, wr});
    end
  end
  always @(negedge i_clk) begin : monitor
    logic [6:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!i_rst) begin
        a = {o_sel, o_enable, o_step, o_running, o_wrap};
        total++;
        if (o_wrap) wraps++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t got sel=%b en=%b step=%0d run=%b wrap=%b want sel=%b en=%b step=%0d run=%b wrap=%b",
                   $time, a[6:5], a[4], a[3:2], a[1], a[0], e[6:5], e[4], e[3:2], e[1], e[0]);
        end
      end
    end
  end
  task automatic tick();
    @(posedge i_clk);
    #3;
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_sel, o_enable, o_step, o_running, o_wrap} !== 7'd0) begin
      bad++;
      $display("FAIL async_reset got %b want 0000000", {o_sel, o_enable, o_step, o_running, o_wrap});
    end
    tick();
    tick();
    i_rst = 1'b0;
  endtask
  task automatic press(int hold);
    i_btn = 1'b1;
    repeat (hold) tick();
    i_btn = 1'b0;
  endtask
  initial begin
    #1;
    do_reset();
    repeat (50) tick();
    i_pattern = 8'b00_01_10_11;
    press(20);
    repeat (60) tick();
    for (int k = 0; k < 8; k++) begin
      i_btn = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      i_btn = 1'b0;
      repeat ($urandom_range(1, 9)) tick();
    end
    press(10);
    i_pattern = 8'($urandom);
    repeat (40) tick();
    press(10);
    repeat (30) tick();
    do_reset();
    i_pattern = 8'b11_00_01_10;
    press(20);
    repeat (8) tick();
    do_reset();
    i_pattern = 8'($urandom);
    press(12);
    repeat (80) tick();
    for (int k = 0; k < 300; k++) begin
      i_btn = 1'($urandom);
      if ($urandom_range(0, 7) == 0) i_pattern = 8'($urandom);
      repeat ($urandom_range(1, 14)) tick();
      if ($urandom_range(0, 59) == 0) do_reset();
    end
    i_btn = 1'b0;
    repeat (10) tick();
    total++;
    if (wraps == 0) begin
      bad++;
      $display("FAIL wrap_seen got %0d want >0", wraps);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
